counter_cmd_driver: RTL and testbench
=====================================

Name: counter_cmd_driver

Overview:
- Drives the control interface of the 4-bit up/down counter: `count`, `up_down`, `load`, `load_input`.
- Turns raw board buttons and switches into clean single-cycle command pulses.
- Processing chain: synchronise, debounce, detect rising edge, register.
- Optional auto mode issues periodic count pulses. Sits between board I/O and the counter block.

Parameters:
- WIDTH, 4, width of `sw_value` and `load_input`.
- DEBOUNCE_CYCLES, 500000, cycles a synchronised input must stay stable before it is accepted (≥2; benches override to 4).
- AUTO_PERIOD, 50000000, cycles between auto count pulses (≥2; benches override to 8).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- btn_count  in  1  raw count button, asynchronous, active-high.
- btn_load  in  1  raw load button, asynchronous, active-high.
- sw_dir  in  1  raw direction switch, 1 = up.
- sw_auto  in  1  raw auto-count enable switch.
- sw_value  in  WIDTH  raw load value switches.
- count  out  1  one-cycle count-enable pulse to the counter.
- up_down  out  1  registered direction level.
- load  out  1  one-cycle load pulse.
- load_input  out  WIDTH  value to load; held stable between loads.

Behaviour:
- Reset (`reset` = 0, asynchronous):
  - All synchroniser flops, debounce counters, stable states, edge history and auto counter clear to 0.
  - Outputs `count` = 0, `up_down` = 0, `load` = 0, `load_input` = 0.
- Synchronisers: every raw input passes through 2 flops (s1, s2). `sw_value` is synchronised per bit; no coherence is guaranteed while the switches are moving.
- Debounce, per button:
  - Registers: `stable` (reset 0) and counter `dcnt` (reset 0).
  - If s2 == `stable`: `dcnt` <= 0.
  - Else if `dcnt` == DEBOUNCE_CYCLES-1: `stable` <= s2, `dcnt` <= 0.
  - Else: `dcnt` <= `dcnt` + 1.
  - Any mismatch run shorter than DEBOUNCE_CYCLES cycles is discarded.
- Edge detection: rise = `stable` & ~`stable_d`, where `stable_d` is `stable` delayed one cycle. Only press edges generate commands; releases generate nothing.
- Latency: take edge 0 as the first clk edge that samples the raw button high.
  - `stable` rises at edge DEBOUNCE_CYCLES+1.
  - The output pulse is high for exactly one cycle, starting at edge DEBOUNCE_CYCLES+2.
- Auto tick:
  - `acnt` runs only while synchronised `sw_auto` = 1; it clears to 0 when `sw_auto` = 0.
  - tick = (`acnt` == AUTO_PERIOD-1), after which `acnt` wraps to 0.
  - First tick comes AUTO_PERIOD cycles after synchronised `sw_auto` rises.
- Output registers, updated every cycle:
  - `load` <= load_rise.
  - `count` <= (count_rise | tick) & ~load_rise. When load and count coincide, load wins and the count is dropped, not deferred.
  - `load_input` <= synchronised `sw_value` when load_rise, else holds.
  - `up_down` <= synchronised `sw_dir`. It is a level; a change reaches the output after 3 edges.
- Mutual exclusion: `count` and `load` are never high in the same cycle.
- Held buttons: a button held continuously gives exactly one pulse, with no auto-repeat.
- Held through reset: a button held during reset release produces one pulse after debounce, because `stable` restarts at 0.
- Reset asserted mid-debounce or mid-auto-period: the partial count is lost and outputs drop to 0 immediately (asynchronous).
- Counter widths: ceil(log2) of the respective parameters. No wrap hazards, because the comparisons are exact.

Decomposition:
- Shared package `trab1_pkg`:
  - Constant for the default WIDTH (4).
  - `clog2` helper function.
  - Default DEBOUNCE_CYCLES and AUTO_PERIOD constants.
- Sub-module `debounce_edge`:
  - Contains 2-flop sync, debounce counter, `stable`, edge detect and `rise` output; parameter DEBOUNCE_CYCLES.
  - Instantiated for `btn_count` and `btn_load`.
- Switch synchronisers and the auto timer stay in the top module.

Test Plan (DEBOUNCE_CYCLES = 4, AUTO_PERIOD = 8):
1. Reset: hold `reset` = 0 with all inputs toggling → all outputs 0. Release with inputs 0 and run 20 cycles → outputs stay 0.
2. Clean press: raise `btn_count` at edge 0 and hold 20 cycles → `count` = 1 only in the cycle beginning at edge 6; `load` stays 0. Release → no pulse.
3. Bounce: `btn_count` pattern 1,1,0,1,1,1,0 then steady 1 → exactly one `count` pulse, at 6 edges after the start of the steady-1 run.
4. Load:
   - `sw_value` = 4'hA settled, press `btn_load` → `load` = 1 for one cycle and `load_input` = 4'hA in that same cycle.
   - Change `sw_value` to 4'h3 without pressing → `load_input` stays 4'hA.
5. Collision: `sw_auto` = 1 with phase aligned so an auto tick coincides with load_rise → `load` = 1, `count` = 0 that cycle. The next count appears 8 cycles later.
6. Auto and direction:
   - `sw_auto` = 1 for 40 cycles → `count` pulses every 8 cycles, the first 8 cycles after the synchronised rise; `sw_auto` = 0 → pulses stop.
   - `sw_dir` 0→1 → `up_down` rises 3 edges later.

Source files
------------

// File: rtl/trab1_pkg.sv
// Shared constants and helpers for the counter command driver.
// Defaults target the board clock; benches override the timing parameters.
package trab1_pkg;

    localparam int DEF_WIDTH           = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_AUTO_PERIOD     = 50000000;

    // One-cycle command strobes produced by the button chains.
    typedef struct packed {
        logic load;
        logic count;
    } cmd_t;

    // Bits needed to hold 0..value-1; never narrower than one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/debounce_edge.sv
// One raw button: 2-flop synchroniser, debounce filter and press-edge detector.
// rise is combinational from registered state and lasts exactly one cycle.
module debounce_edge
    import trab1_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic gclk,
    input  logic grst_n,
    input  logic din,
    output logic rise
);

    localparam int            CW   = clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DMAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1, s2;
    logic          stable, stable_d;
    logic [CW-1:0] dcnt;

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            dcnt     <= '0;
        end else begin
            s1       <= din;
            s2       <= s1;
            stable_d <= stable;
            // Any agreement with the accepted level restarts the mismatch run.
            if (s2 == stable) begin
                dcnt <= '0;
            end else if (dcnt == DMAX) begin
                stable <= s2;
                dcnt   <= '0;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

    assign rise = stable & ~stable_d;

endmodule

// File: rtl/counter_cmd_driver.sv
// Board I/O to counter control: debounced button strobes, auto-count timer,
// synchronised direction level and a load value captured on each load.
module counter_cmd_driver
    import trab1_pkg::*;
#(
    parameter int WIDTH           = DEF_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int AUTO_PERIOD     = DEF_AUTO_PERIOD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_count,
    input  logic             btn_load,
    input  logic             sw_dir,
    input  logic             sw_auto,
    input  logic [WIDTH-1:0] sw_value,
    output logic             count,
    output logic             up_down,
    output logic             load,
    output logic [WIDTH-1:0] load_input
);

    localparam int             NUM_BTN = 2;
    localparam int             SW_W    = WIDTH + 2;
    localparam int             ACW     = clog2(AUTO_PERIOD);
    localparam logic [ACW-1:0] AMAX    = ACW'(AUTO_PERIOD - 1);

    logic [NUM_BTN-1:0] btn_raw, btn_rise;
    cmd_t               rise;

    assign btn_raw = {btn_load, btn_count};

    generate
        for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
            debounce_edge #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .gclk  (clk),
                .grst_n(reset),
                .din   (btn_raw[i]),
                .rise  (btn_rise[i])
            );
        end
    endgenerate

    assign rise.count = btn_rise[0];
    assign rise.load  = btn_rise[1];

    // Switches are synchronised bitwise; sw_value may tear while moving.
    logic [SW_W-1:0]  sw_s1, sw_s2;
    logic             auto_s2, dir_s2;
    logic [WIDTH-1:0] value_s2;
    logic [ACW-1:0]   acnt;
    logic             tick;

    assign {auto_s2, dir_s2, value_s2} = sw_s2;
    assign tick = auto_s2 && (acnt == AMAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_s1      <= '0;
            sw_s2      <= '0;
            acnt       <= '0;
            count      <= 1'b0;
            load       <= 1'b0;
            up_down    <= 1'b0;
            load_input <= '0;
        end else begin
            sw_s1 <= {sw_auto, sw_dir, sw_value};
            sw_s2 <= sw_s1;
            if (!auto_s2 || tick) acnt <= '0;
            else                  acnt <= acnt + 1'b1;
            // Load has priority; a coinciding count is dropped.
            load    <= rise.load;
            count   <= (rise.count | tick) & ~rise.load;
            up_down <= dir_s2;
            if (rise.load) load_input <= value_s2;
        end
    end

endmodule

// File: tb/tb_counter_cmd_driver.sv
// Bench for counter_cmd_driver with short debounce and auto period.
// Reference model works from a history of sampled inputs per clock edge.
module tb_counter_cmd_driver;

    localparam int W    = 4;
    localparam int D    = 4;
    localparam int P    = 8;
    localparam int HMAX = 4096;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         btn_count = 1'b0, btn_load = 1'b0, sw_dir = 1'b0, sw_auto = 1'b0;
    logic [W-1:0] sw_value = '0;
    logic         count, up_down, load;
    logic [W-1:0] load_input;

    counter_cmd_driver #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .AUTO_PERIOD(P)) dut (
        .clk(clk), .reset(reset), .btn_count(btn_count), .btn_load(btn_load),
        .sw_dir(sw_dir), .sw_auto(sw_auto), .sw_value(sw_value),
        .count(count), .up_down(up_down), .load(load), .load_input(load_input)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Raw inputs as sampled at edge k (k counted from reset release).
    bit         hc[HMAX], hl[HMAX], ha[HMAX], hd[HMAX];
    logic [W-1:0] hv[HMAX];
    int         n;
    bit         st_c, st_cp, st_l, st_lp;
    int         arun;
    logic       m_count, m_load, m_ud;
    logic [W-1:0] m_li;

    // Synchronised view: before edge n the second flop holds the sample of edge n-2.
    function automatic bit hist(input int sel, input int k);
        if (k < 0) return 1'b0;
        case (sel)
            0: return hc[k];
            1: return hl[k];
            2: return ha[k];
            default: return hd[k];
        endcase
    endfunction

    function automatic logic [W-1:0] histv(input int k);
        return (k < 0) ? '0 : hv[k];
    endfunction

    task automatic model_reset();
        n = 0; st_c = 0; st_cp = 0; st_l = 0; st_lp = 0; arun = 0;
        m_count = 0; m_load = 0; m_ud = 0; m_li = '0;
    endtask

    // A button's accepted level flips once the synchronised input has
    // disagreed with it for D consecutive edges.
    task automatic model_step();
        bit rc, rl, tk, wc, wl, a;
        rc = st_c & ~st_cp;
        rl = st_l & ~st_lp;
        wc = 1; wl = 1;
        for (int j = 0; j < D; j++) begin
            if (hist(0, n - 2 - j) == st_c) wc = 0;
            if (hist(1, n - 2 - j) == st_l) wl = 0;
        end
        st_cp = st_c; if (wc) st_c = ~st_c;
        st_lp = st_l; if (wl) st_l = ~st_l;
        a = hist(2, n - 2);
        arun = a ? arun + 1 : 0;
        tk = a && (arun % P == 0);
        m_load  = rl;
        m_count = (rc | tk) & ~rl;
        m_ud    = hist(3, n - 2);
        if (rl) m_li = histv(n - 2);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (n >= HMAX) begin
            $display("FAIL history_overflow: edge %0d reached, limit %0d", n, HMAX);
            $fatal(1, "history overflow");
        end
        hc[n] = btn_count; hl[n] = btn_load; ha[n] = sw_auto; hd[n] = sw_dir; hv[n] = sw_value;
        model_step();
        n++;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            {btn_count, btn_load, sw_dir, sw_auto, sw_value} = 8'($urandom);
            #3;
            n_checks++;
            if ({count, load, up_down, load_input} !== 7'd0) begin
                n_fail++; $display("FAIL reset_hold: outputs %b, required 0", {count, load, up_down, load_input});
            end
        end
        {btn_count, btn_load, sw_dir, sw_auto, sw_value} = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            n_checks++;
            if ({count, load, up_down, load_input} !== 7'd0 ||
                {m_count, m_load, m_ud, m_li} !== 7'd0) begin
                n_fail++; $display("FAIL reset_idle edge %0d: got %b model %b required 0", n - 1,
                    {count, load, up_down, load_input}, {m_count, m_load, m_ud, m_li});
            end
        end
    endtask

    task automatic test_clean_press();
        int s;
        s = n;
        btn_count = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (k == 20) btn_count = 1'b0;
            cycle();
            n_checks++;
            if ({count, load, up_down, load_input} !== {m_count, m_load, m_ud, m_li}) begin
                n_fail++; $display("FAIL press_model edge %0d: got %b want %b", n - 1,
                    {count, load, up_down, load_input}, {m_count, m_load, m_ud, m_li});
            end
            n_checks++;
            if (count !== ((n - 1) == s + 6) || load !== 1'b0) begin
                n_fail++; $display("FAIL press_timing k=%0d: count=%b load=%b, required count=%b load=0",
                    k, count, load, ((n - 1) == s + 6));
            end
        end
    endtask

    task automatic test_bounce();
        bit pat [7] = '{1, 1, 0, 1, 1, 1, 0};
        int pulses, at, s;
        pulses = 0; at = -1; s = n;
        for (int k = 0; k < 30; k++) begin
            btn_count = (k < 7) ? pat[k] : 1'b1;
            cycle();
            if (count) begin pulses++; at = k; end
            n_checks++;
            if ({count, load, up_down, load_input} !== {m_count, m_load, m_ud, m_li}) begin
                n_fail++; $display("FAIL bounce_model edge %0d: got %b want %b", n - 1,
                    {count, load, up_down, load_input}, {m_count, m_load, m_ud, m_li});
            end
        end
        n_checks++;
        if (pulses !== 1 || at !== 13) begin
            n_fail++; $display("FAIL bounce_pulse: %0d pulses last at k=%0d, required 1 at k=13", pulses, at);
        end
        btn_count = 1'b0;
        repeat (12) cycle();
    endtask

    task automatic test_load();
        int pulses;
        pulses = 0;
        sw_value = 4'hA;
        repeat (5) cycle();
        btn_load = 1'b1;
        for (int k = 0; k < 15; k++) begin
            cycle();
            if (load) begin
                pulses++;
                n_checks++;
                if (load_input !== 4'hA || count !== 1'b0) begin
                    n_fail++; $display("FAIL load_value: load_input=%h count=%b, required A and 0", load_input, count);
                end
            end
            n_checks++;
            if ({count, load, up_down, load_input} !== {m_count, m_load, m_ud, m_li}) begin
                n_fail++; $display("FAIL load_model edge %0d: got %b want %b", n - 1,
                    {count, load, up_down, load_input}, {m_count, m_load, m_ud, m_li});
            end
        end
        n_checks++;
        if (pulses !== 1) begin
            n_fail++; $display("FAIL load_pulses: %0d, required 1", pulses);
        end
        btn_load = 1'b0;
        repeat (10) cycle();
        sw_value = 4'h3;
        repeat (10) cycle();
        n_checks++;
        if (load_input !== 4'hA || load !== 1'b0) begin
            n_fail++; $display("FAIL load_hold: load_input=%h load=%b, required A and 0", load_input, load);
        end
    endtask

    task automatic test_collision();
        sw_auto = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (k == 11) btn_load = 1'b1;
            cycle();
            n_checks++;
            if ({count, load, up_down, load_input} !== {m_count, m_load, m_ud, m_li}) begin
                n_fail++; $display("FAIL collide_model edge %0d: got %b want %b", n - 1,
                    {count, load, up_down, load_input}, {m_count, m_load, m_ud, m_li});
            end
            if (k >= 17 && k <= 25) begin
                n_checks++;
                if (load !== (k == 17) || count !== (k == 25)) begin
                    n_fail++; $display("FAIL collide_timing k=%0d: load=%b count=%b, required load=%b count=%b",
                        k, load, count, (k == 17), (k == 25));
                end
            end
        end
        btn_load = 1'b0;
        sw_auto  = 1'b0;
        repeat (20) cycle();
    endtask

    task automatic test_auto_dir();
        int pulses;
        pulses = 0;
        sw_auto = 1'b1;
        for (int k = 0; k < 40; k++) begin
            cycle();
            if (count) pulses++;
            n_checks++;
            if (count !== (k >= 9 && (k - 9) % P == 0) || m_count !== count) begin
                n_fail++; $display("FAIL auto_pulse k=%0d: count=%b model=%b", k, count, m_count);
            end
        end
        n_checks++;
        if (pulses !== 4) begin
            n_fail++; $display("FAIL auto_pulses: %0d, required 4", pulses);
        end
        sw_auto = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            n_checks++;
            if ((k >= 2 && count !== 1'b0) || count !== m_count) begin
                n_fail++; $display("FAIL auto_stop k=%0d: count=%b model=%b", k, count, m_count);
            end
        end
        sw_dir = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            n_checks++;
            if (up_down !== (k >= 2) || up_down !== m_ud) begin
                n_fail++; $display("FAIL dir_latency k=%0d: up_down=%b, required %b", k, up_down, (k >= 2));
            end
        end
    endtask

    task automatic test_reset_mid();
        int pulses, at;
        pulses = 0; at = -1;
        btn_count = 1'b1;
        repeat (3) cycle();
        reset = 1'b0;
        #1;
        n_checks++;
        if ({count, load, up_down, load_input} !== 7'd0) begin
            n_fail++; $display("FAIL reset_async: outputs %b, required 0", {count, load, up_down, load_input});
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int k = 0; k < 15; k++) begin
            cycle();
            if (count) begin pulses++; at = k; end
            n_checks++;
            if ({count, load, up_down, load_input} !== {m_count, m_load, m_ud, m_li}) begin
                n_fail++; $display("FAIL held_model edge %0d: got %b want %b", n - 1,
                    {count, load, up_down, load_input}, {m_count, m_load, m_ud, m_li});
            end
        end
        n_checks++;
        if (pulses !== 1 || at !== 6) begin
            n_fail++; $display("FAIL held_reset: %0d pulses last at k=%0d, required 1 at k=6", pulses, at);
        end
        btn_count = 1'b0;
        repeat (10) cycle();
    endtask

    task automatic test_random();
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(5) == 0)  btn_count = ~btn_count;
            if ($urandom_range(7) == 0)  btn_load  = ~btn_load;
            if ($urandom_range(9) == 0)  sw_dir    = ~sw_dir;
            if ($urandom_range(39) == 0) sw_auto   = ~sw_auto;
            if ($urandom_range(4) == 0)  sw_value  = 4'($urandom);
            cycle();
            n_checks++;
            if ({count, load, up_down, load_input} !== {m_count, m_load, m_ud, m_li} || (count & load)) begin
                n_fail++; $display("FAIL random_model edge %0d: got %b want %b", n - 1,
                    {count, load, up_down, load_input}, {m_count, m_load, m_ud, m_li});
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_load();
        test_collision();
        test_auto_dir();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
